// File: rtl/alu_result_serializer.sv
// alu_result_serializer: buffers ALU result/overflow word pairs in a FIFO and replays them
// as one in-order stream, result word first, then overflow word.
// Ports: clock, reset_n (async, active-low);
//        result_valid/result_ack/result_data     primary ALU word input;
//        overflow_valid/overflow_ack/overflow_data secondary ALU word input;
//        out_valid/out_ack/out_data               serialized output stream;
//        out_is_overflow                          head word came from overflow
//                                                 (only when ALU_SERIALIZER_TAG_EN is defined).
module alu_result_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  result_valid,
    output logic                  result_ack,
    input  logic [DATA_WIDTH-1:0] result_data,
    input  logic                  overflow_valid,
    output logic                  overflow_ack,
    input  logic [DATA_WIDTH-1:0] overflow_data,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef ALU_SERIALIZER_TAG_EN
    ,
    output logic                  out_is_overflow
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [1:0] needed, pushed;
    logic accept, pop;
    assign needed = {1'b0, result_valid} + {1'b0, overflow_valid};
    // Free space uses the registered count only, so out_ack never reaches the input acks.
    assign accept = reset_n && needed != 2'd0 && (CW'(FIFO_DEPTH) - count) >= CW'(needed);
    assign result_ack = accept && result_valid;
    assign overflow_ack = accept && overflow_valid;
    assign pushed = accept ? needed : 2'd0;
    assign out_valid = count != '0;
    assign pop = out_valid && out_ack;
    assign out_data = out_valid ? mem[rptr] : '0;
    // The overflow word lands after the result word when both arrive together.
    always_ff @(posedge clock) begin
        if (result_ack)
            mem[wptr] <= result_data;
        if (overflow_ack)
            mem[result_valid ? wptr + AW'(1) : wptr] <= overflow_data;
    end
`ifdef ALU_SERIALIZER_TAG_EN
    logic tag_mem [FIFO_DEPTH];
    assign out_is_overflow = out_valid ? tag_mem[rptr] : 1'b0;
    always_ff @(posedge clock) begin
        if (result_ack)
            tag_mem[wptr] <= 1'b0;
        if (overflow_ack)
            tag_mem[result_valid ? wptr + AW'(1) : wptr] <= 1'b1;
    end
`endif
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(pushed);
            rptr  <= rptr + AW'(pop);
            count <= count + CW'(pushed) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: scoreboard bench for alu_result_serializer against a queue model.
module tb_alu_result_serializer;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic result_valid = 1'b0, overflow_valid = 1'b0, out_ack = 1'b0;
    logic [DW-1:0] result_data = '0, overflow_data = '0;
    logic result_ack, overflow_ack, out_valid;
    logic [DW-1:0] out_data;
`ifdef ALU_SERIALIZER_TAG_EN
    logic out_is_overflow;
`endif
    int checks = 0;
    int fails = 0;
    logic [DW:0] q[$];
    logic [DW:0] pend[$];

    alu_result_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .result_valid(result_valid),
        .result_ack(result_ack),
        .result_data(result_data),
        .overflow_valid(overflow_valid),
        .overflow_ack(overflow_ack),
        .overflow_data(overflow_data),
        .out_valid(out_valid),
        .out_ack(out_ack),
        .out_data(out_data)
`ifdef ALU_SERIALIZER_TAG_EN
        ,
        .out_is_overflow(out_is_overflow)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Words accepted this cycle enter the model at the next edge, matching when the DUT stores them.
    task automatic cycle(input logic rv, input logic [DW-1:0] rd, input logic ov,
                         input logic [DW-1:0] od, input logic oa);
        int need;
        bit acc;
        @(posedge clock);
        while (pend.size() != 0) q.push_back(pend.pop_front());
        #1;
        result_valid = rv;
        result_data = rd;
        overflow_valid = ov;
        overflow_data = od;
        out_ack = oa;
        #1;
        need = int'(rv) + int'(ov);
        acc = need != 0 && (DEPTH - q.size()) >= need;
        check("result_ack", {{DW{1'b0}}, result_ack}, {{DW{1'b0}}, rv && acc});
        check("overflow_ack", {{DW{1'b0}}, overflow_ack}, {{DW{1'b0}}, ov && acc});
        if (acc) begin
            if (rv) pend.push_back({1'b0, rd});
            if (ov) pend.push_back({1'b1, od});
        end
    endtask

    task automatic idle(input int n, input logic oa);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, oa);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        pend.delete();
        #1;
        reset_n = 1'b0;
        result_valid = 1'b0;
        overflow_valid = 1'b0;
        #1;
        check("reset_out_valid", {{DW{1'b0}}, out_valid}, '0);
        check("reset_out_data", {1'b0, out_data}, '0);
        q.delete();
        #2;
        reset_n = 1'b1;
    endtask

    // Monitor: the head of the model queue must be on the output; a handshake retires it.
    always @(negedge clock) begin
        if (reset_n) begin
            check("out_valid", {{DW{1'b0}}, out_valid}, {{DW{1'b0}}, q.size() != 0});
            if (q.size() != 0) begin
                check("out_data", {1'b0, out_data}, {1'b0, q[0][DW-1:0]});
`ifdef ALU_SERIALIZER_TAG_EN
                check("out_is_overflow", {{DW{1'b0}}, out_is_overflow}, {{DW{1'b0}}, q[0][DW]});
`endif
                if (out_ack) void'(q.pop_front());
            end else begin
                check("out_data_empty", {1'b0, out_data}, '0);
            end
        end
    end

    initial begin
        result_valid = 1'b1;
        overflow_valid = 1'b1;
        #2;
        check("rst_result_ack", {{DW{1'b0}}, result_ack}, '0);
        check("rst_overflow_ack", {{DW{1'b0}}, overflow_ack}, '0);
        check("rst_out_valid", {{DW{1'b0}}, out_valid}, '0);
        check("rst_out_data", {1'b0, out_data}, '0);
        result_valid = 1'b0;
        overflow_valid = 1'b0;
        #1 reset_n = 1'b1;
        // single word
        cycle(1'b1, 32'h0000_00A5, 1'b0, '0, 1'b1);
        idle(3, 1'b1);
        // pair order
        cycle(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1);
        idle(4, 1'b1);
        // backpressure until full, third pair stalls
        cycle(1'b1, 32'd1, 1'b1, 32'd2, 1'b0);
        cycle(1'b1, 32'd3, 1'b1, 32'd4, 1'b0);
        cycle(1'b1, 32'd5, 1'b1, 32'd6, 1'b0);
        cycle(1'b1, 32'd5, 1'b1, 32'd6, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'd5, 1'b1, 32'd6, 1'b1);
        idle(6, 1'b1);
        // partial space: count 3 blocks a pair, a pop frees room for the next cycle
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h30 + i, 1'b0, '0, 1'b0);
        cycle(1'b1, 32'hA0, 1'b1, 32'hB0, 1'b0);
        cycle(1'b1, 32'hA0, 1'b1, 32'hB0, 1'b1);
        cycle(1'b1, 32'hA0, 1'b1, 32'hB0, 1'b0);
        idle(6, 1'b1);
        // streaming singles across pointer wrap
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h100 + i, 1'b0, '0, 1'b1);
        idle(3, 1'b1);
        // overflow-only word
        cycle(1'b0, '0, 1'b1, 32'h0BAD_F00D, 1'b1);
        idle(2, 1'b1);
        // reset mid-operation
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + i, 1'b0, '0, 1'b0);
        idle(1, 1'b0);
        pulse_reset();
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b1);
        idle(3, 1'b1);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            cycle(sel[0], $urandom, sel[1], $urandom, $urandom_range(0, 3) != 0);
        end
        idle(10, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
